// File: rtl/image_processor_pkg.sv
// Shared types and constants for the image capture path.
// Pixel/address typedefs, frame geometry and packer states.
package image_processor_pkg;

  localparam int IMG_W = 512;
  localparam int IMG_H = 384;
  localparam int IMG_PIXELS = IMG_W * IMG_H;

  typedef logic [23:0] pixel_t;
  typedef logic [17:0] bram_addr_t;

  typedef enum logic [1:0] {
    S_R,
    S_G,
    S_B
  } pack_state_t;

  function automatic pixel_t pack_rgb(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r, g, b};
  endfunction

endpackage

// File: rtl/uart_pixel_packer_if.sv
// BRAM port A write bundle driven by the pixel packer.
// master = packer side, slave = BRAM side.
interface uart_pixel_packer_if #(
  parameter int ADDR_W = 18
);
  import image_processor_pkg::*;

  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  pixel_t            din;

  modport master (
    output en,
    output we,
    output addr,
    output din
  );

  modport slave (
    input en,
    input we,
    input addr,
    input din
  );

endinterface

// File: rtl/uart_pixel_packer_idle_timeout.sv
// Idle-cycle counter used to age out a partial pixel.
// expire is combinational: run && count at TIMEOUT_CYCLES-1.
module idle_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign expire = run && (cnt_q == LAST);

  // clear has priority, otherwise count idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_pixel_packer.sv
// Packs UART R,G,B byte triples into 24-bit BRAM writes.
// Option: UART_PIXEL_PACKER_CHECKSUM_EN adds frame_sum.
module uart_pixel_packer
  import image_processor_pkg::*;
#(
  parameter int NUM_PIXELS     = IMG_PIXELS,
  parameter int ADDR_W         = 18,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_received,
  input  logic        rx_data_ready,
  input  logic        frame_restart,
  uart_pixel_packer_if.master bram,
  output logic        frame_done,
  output logic        drop_pulse,
`ifdef UART_PIXEL_PACKER_CHECKSUM_EN
  output logic [15:0] frame_sum,
`endif
  output logic        busy
);

  localparam logic [ADDR_W-1:0] LAST_PIX =
    ADDR_W'(NUM_PIXELS - 1);

  pack_state_t       state_q;
  pack_state_t       state_d;
  logic [7:0]        r_q;
  logic [7:0]        g_q;
  logic [ADDR_W-1:0] pix_q;
  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  pixel_t            din_q;
  logic              wr_fire;
  logic              drop_fire;
  logic              tmo_run;
  logic              tmo_clear;
  logic              tmo_expire;
  logic              take;
  logic              last_pix;

  assign take     = rx_data_ready && !frame_restart;
  assign last_pix = (pix_q == LAST_PIX);

  assign tmo_run   = (state_q != S_R) && !rx_data_ready;
  assign tmo_clear = rx_data_ready || frame_restart ||
                     (state_q == S_R) || tmo_expire;

  idle_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmo_clear),
    .run   (tmo_run),
    .expire(tmo_expire)
  );

  // byte phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_R;
    end else begin
      state_q <= state_d;
    end
  end

  // next phase; a byte beats a same-cycle timeout
  always_comb begin
    state_d   = state_q;
    wr_fire   = 1'b0;
    drop_fire = 1'b0;
    if (frame_restart) begin
      state_d = S_R;
    end else begin
      unique case (state_q)
        S_R: begin
          if (rx_data_ready) state_d = S_G;
        end
        S_G: begin
          if (rx_data_ready) begin
            state_d = S_B;
          end else if (tmo_expire) begin
            state_d   = S_R;
            drop_fire = 1'b1;
          end
        end
        S_B: begin
          if (rx_data_ready) begin
            state_d = S_R;
            wr_fire = 1'b1;
          end else if (tmo_expire) begin
            state_d   = S_R;
            drop_fire = 1'b1;
          end
        end
        default: state_d = S_R;
      endcase
    end
  end

  // R and G holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
    end else if (take) begin
      if (state_q == S_R) r_q <= byte_received;
      if (state_q == S_G) g_q <= byte_received;
    end
  end

  // BRAM write port, pixel counter and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      pix_q      <= '0;
      frame_done <= 1'b0;
      drop_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      en_q       <= wr_fire;
      frame_done <= wr_fire && last_pix;
      drop_pulse <= drop_fire;
      busy       <= (state_d != S_R);
      if (wr_fire) begin
        addr_q <= pix_q;
        din_q  <= pack_rgb(r_q, g_q, byte_received);
      end
      if (frame_restart) begin
        pix_q <= '0;
      end else if (wr_fire) begin
        pix_q <= last_pix ? '0 : pix_q + ADDR_W'(1);
      end
    end
  end

  assign bram.en   = en_q;
  assign bram.we   = en_q;
  assign bram.addr = addr_q;
  assign bram.din  = din_q;

`ifdef UART_PIXEL_PACKER_CHECKSUM_EN
  logic [15:0] run_sum_q;
  logic [15:0] sum_next;

  assign sum_next = run_sum_q + {8'h00, r_q} +
                    {8'h00, g_q} + {8'h00, byte_received};

  // running byte sum of committed pixels, latched per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sum_q <= '0;
      frame_sum <= '0;
    end else if (frame_restart) begin
      run_sum_q <= '0;
    end else if (wr_fire) begin
      if (last_pix) begin
        frame_sum <= sum_next;
        run_sum_q <= '0;
      end else begin
        run_sum_q <= sum_next;
      end
    end
  end
`endif

endmodule
